// File: rtl/sdram_rr_arbiter.sv
// Two-port round-robin arbiter in front of a single SDRAM controller user interface.
// One latched request at a time; read watchdog completes stuck reads with an error.
module sdram_rr_arbiter #(
    parameter int unsigned ADDR_W     = 23,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned RD_TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                m0_req,
    input  logic                m0_we,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_sel,
    output logic                m0_ack,
    output logic                m0_err,
    output logic [DATA_W-1:0]   m0_rdata,

    input  logic                m1_req,
    input  logic                m1_we,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_sel,
    output logic                m1_ack,
    output logic                m1_err,
    output logic [DATA_W-1:0]   m1_rdata,

    output logic [ADDR_W-1:0]   ctrl_user_addr,
    output logic                ctrl_rw,
    output logic [DATA_W-1:0]   ctrl_data_in,
    output logic [DATA_W/8-1:0] ctrl_mask,
    output logic                ctrl_in_valid,
    input  logic                ctrl_busy,
    input  logic                ctrl_out_valid,
    input  logic [DATA_W-1:0]   ctrl_data_out,

    output logic                owner,
    output logic                active
);

    localparam int unsigned SEL_W   = DATA_W / 8;
    localparam logic [7:0]  TIMEOUT = 8'(RD_TIMEOUT);

    typedef enum logic [1:0] {StIdle, StIssue, StWaitRd, StResp} state_e;

    state_e              r_state, w_state_d;
    logic                r_owner, r_rr_ptr, r_active, r_we, r_err;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata, r_rdata;
    logic [SEL_W-1:0]    r_sel;
    logic [7:0]          r_cnt;

    logic                w_grant, w_grant_port, w_timeout, w_resp;
    logic [7:0]          w_cnt_inc;

    always_comb begin
        w_grant      = 1'b0;
        w_grant_port = r_rr_ptr;
        if (r_state == StIdle && !ctrl_busy) begin
            if (m0_req && m1_req) begin
                w_grant      = 1'b1;
                w_grant_port = r_rr_ptr;
            end else if (m0_req) begin
                w_grant      = 1'b1;
                w_grant_port = 1'b0;
            end else if (m1_req) begin
                w_grant      = 1'b1;
                w_grant_port = 1'b1;
            end
        end
    end

    // The watchdog compares the post-increment count, so WAIT_RD lasts at most RD_TIMEOUT cycles.
    assign w_cnt_inc = r_cnt + 8'd1;
    assign w_timeout = (w_cnt_inc == TIMEOUT);

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle:   if (w_grant) w_state_d = StIssue;
            StIssue:  if (!ctrl_busy) w_state_d = r_we ? StResp : StWaitRd;
            StWaitRd: if (ctrl_out_valid || w_timeout) w_state_d = StResp;
            StResp:   w_state_d = StIdle;
            default:  w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_active <= 1'b0;
            r_owner  <= 1'b0;
            r_rr_ptr <= 1'b0;
            r_we     <= 1'b0;
            r_err    <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_sel    <= '0;
            r_rdata  <= '0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_d;
            r_active <= (w_state_d != StIdle);
            if (w_grant) begin
                r_owner  <= w_grant_port;
                r_rr_ptr <= ~w_grant_port;
                r_err    <= 1'b0;
                r_we     <= w_grant_port ? m1_we    : m0_we;
                r_addr   <= w_grant_port ? m1_addr  : m0_addr;
                r_wdata  <= w_grant_port ? m1_wdata : m0_wdata;
                r_sel    <= w_grant_port ? m1_sel   : m0_sel;
            end
            if (r_state == StIssue && !ctrl_busy && !r_we) begin
                r_cnt <= '0;
            end else if (r_state == StWaitRd) begin
                r_cnt <= w_cnt_inc;
            end
            // out_valid takes priority over a coincident timeout
            if (r_state == StWaitRd) begin
                if (ctrl_out_valid) begin
                    r_rdata <= ctrl_data_out;
                end else if (w_timeout) begin
                    r_rdata <= '0;
                    r_err   <= 1'b1;
                end
            end
        end
    end

    assign w_resp         = (r_state == StResp);
    assign m0_ack         = w_resp & ~r_owner;
    assign m1_ack         = w_resp & r_owner;
    assign m0_err         = m0_ack & r_err;
    assign m1_err         = m1_ack & r_err;
    assign m0_rdata       = {DATA_W{m0_ack}} & r_rdata;
    assign m1_rdata       = {DATA_W{m1_ack}} & r_rdata;

    assign ctrl_in_valid  = (r_state == StIssue);
    assign ctrl_user_addr = r_addr;
    assign ctrl_rw        = r_we;
    assign ctrl_data_in   = r_wdata;
    assign ctrl_mask      = r_we ? r_sel : '0;

    assign owner          = r_owner;
    assign active         = r_active;

endmodule
